// File: rtl/des_pkg.sv
// DES constant tables, engine state encoding and the bit-manipulation helpers
// shared by the round engine and its single-round datapath.
package des_pkg;
    typedef int tbl_t [64];
    typedef int shift_t [16];
    typedef int sbox_t [8][64];
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Entries use DES numbering (bit 1 = MSB); short tables are zero padded to 64.
    localparam tbl_t IP = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam tbl_t FP = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
    localparam tbl_t E = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1,
        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    localparam tbl_t P = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25,
        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    localparam tbl_t PC1 = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18, 10, 2,
        59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36, 63, 55, 47, 39,
        31, 23, 15, 7, 62, 54, 46, 38, 30, 22, 14, 6, 61, 53, 45, 37,
        29, 21, 13, 5, 28, 20, 12, 4, 0, 0, 0, 0, 0, 0, 0, 0};
    localparam tbl_t PC2 = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4,
        26, 8, 16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32,
        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    localparam shift_t SHIFT  = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam shift_t RSHIFT = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Each box is indexed by row*16 + column, row = {b1, b6}, column = b2..b5.
    localparam sbox_t SBOX = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    // Result is MSB-aligned in the low out_w bits; input is MSB-aligned in the low in_w bits.
    function automatic logic [63:0] permute(input logic [63:0] x, input int in_w,
                                            input tbl_t t, input int out_w);
        logic [63:0] y;
        logic [5:0]  src;
        logic [5:0]  dst;
        y = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < out_w) begin
                src = 6'(in_w - t[i]);
                dst = 6'(out_w - 1 - i);
                y[dst] = x[src];
            end
        end
        return y;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
        return (x << n) | (x >> (28 - n));
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
        return (x >> n) | (x << (28 - n));
    endfunction

    function automatic logic [3:0] sbox(input logic [2:0] n, input logic [5:0] six);
        int v;
        v = SBOX[n][{six[5], six[0], six[4:1]}];
        return 4'(v);
    endfunction
endpackage

// File: rtl/des_round_engine_if.sv
// Block/key input handshake and result output handshake of the DES round engine.
interface des_round_engine_if;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic [1:64] key_in;
    logic [1:64] din;
    logic        out_valid;
    logic        out_ready;
    logic [1:64] dout;
    logic        busy;

    modport master (output in_valid, mode, key_in, din, out_ready,
                    input  in_ready, out_valid, dout, busy);
    modport slave  (input  in_valid, mode, key_in, din, out_ready,
                    output in_ready, out_valid, dout, busy);
endinterface

// File: rtl/des_round.sv
// One combinational DES Feistel round, including the on-the-fly rotation of the
// C/D key-schedule halves that produces this round's subkey.
module des_round
    import des_pkg::*;
(
    input  logic [1:32] l,
    input  logic [1:32] r,
    input  logic [1:28] c,
    input  logic [1:28] d,
    input  logic [4:0]  rnd,
    input  logic        mode,
    output logic [1:32] l_next,
    output logic [1:32] r_next,
    output logic [1:28] c_next,
    output logic [1:28] d_next
);
    logic [3:0]  idx;
    logic [1:48] k;
    logic [1:48] x;
    logic [1:32] s_out;

    assign idx = 4'(rnd - 5'd1);

    // Decrypt walks the schedule backwards: round 1 uses the unrotated halves (K16).
    assign c_next = mode ? rotr28(c, RSHIFT[idx]) : rotl28(c, SHIFT[idx]);
    assign d_next = mode ? rotr28(d, RSHIFT[idx]) : rotl28(d, SHIFT[idx]);

    assign k = 48'(permute({8'b0, c_next, d_next}, 56, PC2, 48));
    assign x = k ^ 48'(permute({32'b0, r}, 32, E, 48));

    for (genvar g = 0; g < 8; g++) begin : g_sbox
        assign s_out[4*g+1 +: 4] = sbox(3'(g), x[6*g+1 +: 6]);
    end

    assign l_next = r;
    assign r_next = l ^ 32'(permute({32'b0, s_out}, 32, P, 32));
endmodule

// File: rtl/des_round_engine.sv
// Iterative DES encrypt/decrypt core evaluating ROUNDS_PER_CYCLE Feistel rounds per
// clock, with valid/ready handshakes on the input block and the result.
module des_round_engine
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input logic               clk,
    input logic               rst,
    des_round_engine_if.slave bus
);
    localparam logic [4:0] STEP     = 5'(ROUNDS_PER_CYCLE);
    localparam logic [4:0] LAST_RND = 5'd16 - STEP;

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
          ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
        $error("des_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    state_t      state;
    logic [1:32] l_q, r_q;
    logic [1:28] c_q, d_q;
    logic        mode_q;
    logic [4:0]  rnd;
    logic [1:64] dout_q;
    logic        in_ready_q, out_valid_q, busy_q;

    logic [1:32] l_c [0:ROUNDS_PER_CYCLE];
    logic [1:32] r_c [0:ROUNDS_PER_CYCLE];
    logic [1:28] c_c [0:ROUNDS_PER_CYCLE];
    logic [1:28] d_c [0:ROUNDS_PER_CYCLE];
    logic [1:64] ip_blk, fp_blk;
    logic [1:56] pc1_key;

    assign l_c[0] = l_q;
    assign r_c[0] = r_q;
    assign c_c[0] = c_q;
    assign d_c[0] = d_q;

    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
        des_round u_round (
            .l      (l_c[g]),
            .r      (r_c[g]),
            .c      (c_c[g]),
            .d      (d_c[g]),
            .rnd    (rnd + 5'(g + 1)),
            .mode   (mode_q),
            .l_next (l_c[g+1]),
            .r_next (r_c[g+1]),
            .c_next (c_c[g+1]),
            .d_next (d_c[g+1])
        );
    end

    assign ip_blk  = permute(bus.din, 64, IP, 64);
    assign pc1_key = 56'(permute(bus.key_in, 64, PC1, 56));
    // The last round's swap is undone by feeding {R16, L16} to the final permutation.
    assign fp_blk  = permute({r_c[ROUNDS_PER_CYCLE], l_c[ROUNDS_PER_CYCLE]}, 64, FP, 64);

    // NOTE: all state updates are non-blocking so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            dout_q      <= '0;
            rnd         <= '0;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            mode_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid && in_ready_q) begin
                    {l_q, r_q} <= ip_blk;
                    {c_q, d_q} <= pc1_key;
                    mode_q     <= bus.mode;
                    rnd        <= '0;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                    state      <= RUN;
                end
                RUN: begin
                    l_q <= l_c[ROUNDS_PER_CYCLE];
                    r_q <= r_c[ROUNDS_PER_CYCLE];
                    c_q <= c_c[ROUNDS_PER_CYCLE];
                    d_q <= d_c[ROUNDS_PER_CYCLE];
                    rnd <= rnd + STEP;
                    if (rnd == LAST_RND) begin
                        dout_q      <= fp_blk;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_des_round_engine.sv
// Bench for des_round_engine instantiated at unroll factors 1, 2, 4 and 16.
module tb_des_round_engine;
    import des_pkg::*;

    localparam logic [63:0] KEY1  = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT1   = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT1   = 64'h85E813540F0AB405;
    localparam logic [63:0] KEY2  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] KEY2P = 64'h0F339333EB6C0C72;
    localparam logic [63:0] PT2   = 64'h8787878787878787;
    localparam int LAT [4] = '{16, 8, 4, 1};

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, mode;
    logic [63:0] key_in, din;
    int          sel;
    logic [3:0]  ov, ir, bz;
    logic [63:0] dv [4];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        localparam int RPC = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 4 : 16;
        des_round_engine_if bif ();
        assign bif.in_valid  = in_valid && (sel == k);
        assign bif.out_ready = out_ready && (sel == k);
        assign bif.mode      = mode;
        assign bif.key_in    = key_in;
        assign bif.din       = din;
        des_round_engine #(.ROUNDS_PER_CYCLE(RPC)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bif)
        );
        assign ov[k] = bif.out_valid;
        assign ir[k] = bif.in_ready;
        assign bz[k] = bif.busy;
        assign dv[k] = bif.dout;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference model: textbook DES with a precomputed subkey list, reversed for decrypt.
    function automatic logic [63:0] pick(input logic [63:0] x, input int in_w,
                                         input tbl_t t, input int out_w);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < out_w; i++) y[6'(out_w - 1 - i)] = x[6'(in_w - t[i])];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [5:0]  six;
        int          row, col;
        x = 48'(pick({32'b0, r}, 32, E, 48)) ^ k;
        s = '0;
        for (int n = 0; n < 8; n++) begin
            six = x[47 - 6*n -: 6];
            row = 2 * int'(six[5]) + int'(six[0]);
            col = int'(six[4:1]);
            s   = (s << 4) | 32'(SBOX[n][row * 16 + col]);
        end
        return 32'(pick({32'b0, s}, 32, P, 32));
    endfunction

    function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] blk,
                                            input logic decrypt);
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [63:0] t;
        logic [31:0] l, r, tmp;
        t = pick(key, 64, PC1, 56);
        c = t[55:28];
        d = t[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < SHIFT[i]; j++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            ks[i] = 48'(pick({8'b0, c, d}, 56, PC2, 48));
        end
        t = pick(blk, 64, IP, 64);
        l = t[63:32];
        r = t[31:0];
        for (int i = 0; i < 16; i++) begin
            tmp = r;
            r   = l ^ feistel(r, decrypt ? ks[15 - i] : ks[i]);
            l   = tmp;
        end
        return pick({r, l}, 64, FP, 64);
    endfunction

    task automatic wait_out(input int idx, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ov[idx] && lat < 64);
    endtask

    task automatic release_out(input int idx);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_after_handshake", ov[idx], 1'b0);
    endtask

    task automatic run_block(input int idx, input logic [63:0] key, input logic [63:0] blk,
                             input logic m, input bit scramble, output logic [63:0] res);
        int lat;
        @(negedge clk);
        sel = idx; key_in = key; din = blk; mode = m; in_valid = 1'b1;
        check("ready_before_accept", ir[idx], 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("busy_after_accept", bz[idx], 1'b1);
        if (scramble) begin
            mode   = ~m;
            key_in = {$urandom, $urandom};
            din    = {$urandom, $urandom};
        end
        wait_out(idx, lat);
        check($sformatf("latency_dut%0d", idx), lat, LAT[idx]);
        res = dv[idx];
        release_out(idx);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] res, ct, saved, k, x;
        int          lat;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0;
        key_in = '0; din = '0; sel = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("reset_in_ready", ir[i], 1'b1);
            check("reset_out_valid", ov[i], 1'b0);
            check("reset_busy", bz[i], 1'b0);
            check("reset_dout", dv[i], 64'd0);
        end
        rst = 1'b0;

        run_block(0, KEY1, PT1, 1'b0, 1'b0, res);
        check("kat_encrypt", res, CT1);
        for (int i = 0; i < 4; i++) begin
            run_block(i, KEY1, CT1, 1'b1, 1'b0, res);
            check($sformatf("kat_decrypt_dut%0d", i), res, PT1);
        end
        run_block(0, KEY2, PT2, 1'b0, 1'b0, res);
        check("kat_zero", res, 64'd0);
        run_block(2, KEY2P, PT2, 1'b0, 1'b0, res);
        check("kat_parity_ignored", res, 64'd0);

        // Backpressure: in_valid stays high with a second block the whole time.
        @(negedge clk);
        sel = 0; key_in = KEY1; din = PT1; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        k = {$urandom, $urandom};
        x = {$urandom, $urandom};
        key_in = k; din = x; mode = 1'b1;
        wait_out(0, lat);
        check("bp_latency", lat, 16);
        check("bp_dout", dv[0], CT1);
        saved = dv[0];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_valid", ov[0], 1'b1);
            check("bp_hold_dout", dv[0], saved);
            check("bp_hold_in_ready", ir[0], 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_in_ready_after_hs", ir[0], 1'b1);
        check("bp_no_accept_at_hs", bz[0], 1'b0);
        check("bp_valid_dropped", ov[0], 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_second_accepted", bz[0], 1'b1);
        wait_out(0, lat);
        check("bp_second_latency", lat, 16);
        check("bp_second_dout", dv[0], des_ref(k, x, 1'b1));
        release_out(0);

        // Reset while round 7 is being evaluated.
        @(negedge clk);
        sel = 0; key_in = KEY1; din = PT1; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", ov[0], 1'b0);
        check("midrst_in_ready", ir[0], 1'b1);
        check("midrst_busy", bz[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_no_output", ov[0], 1'b0);
        run_block(0, KEY1, PT1, 1'b0, 1'b0, res);
        check("midrst_next_block", res, CT1);

        for (int i = 0; i < 100; i++) begin
            k = {$urandom, $urandom};
            x = {$urandom, $urandom};
            run_block(i % 4, k, x, 1'b0, 1'b1, ct);
            check("rand_encrypt", ct, des_ref(k, x, 1'b0));
            run_block((i + 1) % 4, k, ct, 1'b1, 1'b1, res);
            check("rand_roundtrip", res, x);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
